// File: rtl/acorn128_stream_engine.sv
// rtl/acorn128_stream_engine.sv - ACORN-128 v3 AEAD stream engine, DW state-update steps per clock
module acorn128_stream_engine #(
    parameter int DW   = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic            decrypt_in,
    input  logic [127:0]    key_in,
    input  logic [127:0]    iv_in,
    input  logic [LENW-1:0] ad_words_in,
    input  logic [LENW-1:0] msg_words_in,
    input  logic [127:0]    tag_in,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic            busy_out,
    output logic            done_out,
    output logic [127:0]    tag_out,
    output logic            tag_ok_out
);
    localparam int INIT_CYC = 1792 / DW;
    localparam int PAD_CYC  = 256 / DW;
    localparam int FIN_CYC  = 768 / DW;
    localparam int HALF_CYC = 128 / DW;
    localparam int CW       = $clog2(INIT_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_AD, S_AD_PAD, S_MSG, S_MSG_PAD, S_FINAL, S_DONE
    } state_t;

    state_t            fsm, fsm_nxt;
    logic [292:0]      acorn, acorn_nxt;
    logic [CW-1:0]     cnt;
    logic [LENW-1:0]   wcnt;
    logic [LENW-1:0]   msg_words_q;
    logic              dec_q;
    logic [127:0]      key_q, iv_q, tag_exp_q;
    logic              drain, step_en, step_ca, step_cb, step_dec;
    logic [DW-1:0]     step_word, ks_word, init_word;
    logic [31:0]       init_pos;
    logic [127:0]      tag_nxt;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Load stream: key, then IV, then key repeating with bit 256 inverted
    always_comb begin
        init_pos  = 32'(cnt) * 32'(DW);
        init_word = DW'(key_q >> (init_pos % 32'd128));
        if (init_pos >= 32'd128 && init_pos < 32'd256)
            init_word = DW'(iv_q >> (init_pos % 32'd128));
        else if (init_pos == 32'd256)
            init_word[0] = ~init_word[0];
    end

    always_comb begin
        fsm_nxt   = fsm;
        step_en   = 1'b0;
        step_word = '0;
        step_ca   = 1'b1;
        step_cb   = 1'b1;
        step_dec  = 1'b0;
        in_ready  = 1'b0;
        drain     = !out_valid || out_ready;
        case (fsm)
            S_IDLE: if (start_in) fsm_nxt = S_INIT;
            S_INIT: begin
                step_en   = 1'b1;
                step_word = init_word;
                if (cnt == CW'(INIT_CYC - 1)) fsm_nxt = (wcnt != '0) ? S_AD : S_AD_PAD;
            end
            S_AD: begin
                in_ready  = 1'b1;
                step_en   = in_valid;
                step_word = in_data;
                if (in_valid && wcnt == LENW'(1)) fsm_nxt = S_AD_PAD;
            end
            S_AD_PAD: begin
                step_en   = 1'b1;
                step_word = (cnt == '0) ? DW'(1) : '0;
                step_ca   = cnt < CW'(HALF_CYC);
                if (cnt == CW'(PAD_CYC - 1)) fsm_nxt = (msg_words_q != '0) ? S_MSG : S_MSG_PAD;
            end
            S_MSG: begin
                in_ready  = drain;
                step_en   = in_valid && drain;
                step_word = in_data;
                step_cb   = 1'b0;
                step_dec  = dec_q;
                if (step_en && wcnt == LENW'(1)) fsm_nxt = S_MSG_PAD;
            end
            S_MSG_PAD: begin
                // Hold padding until the last output word has left
                step_en   = drain;
                step_word = (cnt == '0) ? DW'(1) : '0;
                step_ca   = cnt < CW'(HALF_CYC);
                step_cb   = 1'b0;
                if (drain && cnt == CW'(PAD_CYC - 1)) fsm_nxt = S_FINAL;
            end
            S_FINAL: begin
                step_en = 1'b1;
                if (cnt == CW'(FIN_CYC - 1)) fsm_nxt = S_DONE;
            end
            S_DONE:  fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // DW unrolled state-update steps; word bit 0 goes first
    always_comb begin : step_chain
        logic [292:0] s;
        logic         ks, mb, fb;
        s       = acorn;
        ks      = 1'b0;
        mb      = 1'b0;
        fb      = 1'b0;
        ks_word = '0;
        for (int j = 0; j < DW; j++) begin
            s[289] = s[289] ^ s[235] ^ s[230];
            s[230] = s[230] ^ s[196] ^ s[193];
            s[193] = s[193] ^ s[160] ^ s[154];
            s[154] = s[154] ^ s[111] ^ s[107];
            s[107] = s[107] ^ s[66]  ^ s[61];
            s[61]  = s[61]  ^ s[23]  ^ s[0];
            ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
            mb = step_word[j] ^ (step_dec & ks);
            fb = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (step_ca & s[196]) ^ (step_cb & ks);
            s  = {fb ^ mb, s[292:1]};
            ks_word[j] = ks;
        end
        acorn_nxt = s;
    end

    assign tag_nxt  = 128'({ks_word, tag_out} >> DW);
    assign busy_out = (fsm != S_IDLE);
    assign done_out = (fsm == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm         <= S_IDLE;
            acorn       <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            msg_words_q <= '0;
            dec_q       <= 1'b0;
            key_q       <= '0;
            iv_q        <= '0;
            tag_exp_q   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            tag_out     <= '0;
            tag_ok_out  <= 1'b0;
        end else begin
            fsm <= fsm_nxt;
            if (fsm_nxt != fsm)
                cnt <= '0;
            else if (step_en && fsm != S_AD && fsm != S_MSG)
                cnt <= cnt + CW'(1);
            if (fsm == S_IDLE) begin
                if (start_in) begin
                    acorn       <= '0;
                    wcnt        <= ad_words_in;
                    msg_words_q <= msg_words_in;
                    dec_q       <= decrypt_in;
                    key_q       <= key_in;
                    iv_q        <= iv_in;
                    tag_exp_q   <= tag_in;
                    tag_out     <= '0;
                    tag_ok_out  <= 1'b0;
                end
            end else begin
                if (step_en) acorn <= acorn_nxt;
                if (fsm == S_AD_PAD && fsm_nxt != fsm)
                    wcnt <= msg_words_q;
                else if ((fsm == S_AD || fsm == S_MSG) && step_en)
                    wcnt <= wcnt - LENW'(1);
                if (fsm == S_MSG && step_en) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data ^ ks_word;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (fsm == S_FINAL) tag_out <= tag_nxt;
                if (fsm == S_FINAL && fsm_nxt == S_DONE)
                    tag_ok_out <= !dec_q || (tag_nxt == tag_exp_q);
            end
        end
    end
endmodule

// File: tb/tb_acorn128_stream_engine.sv
// tb/tb_acorn128_stream_engine.sv - directed self-checking bench for acorn128_stream_engine at DW 8/32/128
module tb_acorn128_stream_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   start;
    logic         decrypt;
    logic [127:0] key, iv, tag_exp;
    logic [15:0]  ad_words, msg_words;
    logic         in_valid, out_ready;
    logic [127:0] in_data;
    logic [2:0]   rdy, ov, busy, done, tok;
    logic [7:0]   od8;
    logic [31:0]  od32;
    logic [127:0] od128;
    logic [127:0] tg [3];
    int           sel;
    logic [127:0] cur_od;

    int tests = 0;
    int fails = 0;
    bit ms [293];

    acorn128_stream_engine #(.DW(8), .LENW(16)) u8 (
        .clk(clk), .rst(rst_n), .start_in(start[0]), .decrypt_in(decrypt), .key_in(key), .iv_in(iv),
        .ad_words_in(ad_words), .msg_words_in(msg_words), .tag_in(tag_exp), .in_valid(in_valid),
        .in_data(in_data[7:0]), .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od8), .out_ready(out_ready),
        .busy_out(busy[0]), .done_out(done[0]), .tag_out(tg[0]), .tag_ok_out(tok[0]));

    acorn128_stream_engine #(.DW(32), .LENW(16)) u32 (
        .clk(clk), .rst(rst_n), .start_in(start[1]), .decrypt_in(decrypt), .key_in(key), .iv_in(iv),
        .ad_words_in(ad_words), .msg_words_in(msg_words), .tag_in(tag_exp), .in_valid(in_valid),
        .in_data(in_data[31:0]), .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od32), .out_ready(out_ready),
        .busy_out(busy[1]), .done_out(done[1]), .tag_out(tg[1]), .tag_ok_out(tok[1]));

    acorn128_stream_engine #(.DW(128), .LENW(16)) u128 (
        .clk(clk), .rst(rst_n), .start_in(start[2]), .decrypt_in(decrypt), .key_in(key), .iv_in(iv),
        .ad_words_in(ad_words), .msg_words_in(msg_words), .tag_in(tag_exp), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy[2]), .out_valid(ov[2]), .out_data(od128), .out_ready(out_ready),
        .busy_out(busy[2]), .done_out(done[2]), .tag_out(tg[2]), .tag_ok_out(tok[2]));

    always_comb begin
        cur_od = '0;
        case (sel)
            0:       cur_od = {120'd0, od8};
            1:       cur_od = {96'd0, od32};
            default: cur_od = od128;
        endcase
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Bit-serial reference following the published reference-C step
    task automatic ref_step(input bit m, input bit ca, input bit cb, output bit ks);
        bit f;
        ms[289] = ms[289] ^ ms[235] ^ ms[230];
        ms[230] = ms[230] ^ ms[196] ^ ms[193];
        ms[193] = ms[193] ^ ms[160] ^ ms[154];
        ms[154] = ms[154] ^ ms[111] ^ ms[107];
        ms[107] = ms[107] ^ ms[66]  ^ ms[61];
        ms[61]  = ms[61]  ^ ms[23]  ^ ms[0];
        ks = ms[12] ^ ms[154] ^ ((ms[235] & ms[61]) ^ (ms[235] & ms[193]) ^ (ms[61] & ms[193]))
             ^ ((ms[230] & ms[111]) ^ (~ms[230] & ms[66]));
        f = ms[0] ^ ~ms[107] ^ ((ms[244] & ms[23]) ^ (ms[244] & ms[160]) ^ (ms[23] & ms[160]))
            ^ (ca & ms[196]) ^ (cb & ks);
        for (int j = 0; j < 292; j++) ms[j] = ms[j+1];
        ms[292] = f ^ m;
    endtask

    task automatic ref_run(input logic [127:0] k, input logic [127:0] v, input logic [127:0] ad,
                           input logic [127:0] msg, input bit has_ad, input bit has_msg,
                           output logic [127:0] ct, output logic [127:0] tag);
        bit ks, m;
        ct = '0;
        tag = '0;
        for (int i = 0; i < 293; i++) ms[i] = 1'b0;
        for (int i = 0; i < 1792; i++) begin
            if (i < 128)      m = k[i];
            else if (i < 256) m = v[i-128];
            else              m = k[i%128] ^ (i == 256);
            ref_step(m, 1'b1, 1'b1, ks);
        end
        if (has_ad) for (int i = 0; i < 128; i++) ref_step(ad[i], 1'b1, 1'b1, ks);
        for (int i = 0; i < 256; i++) ref_step(i == 0, i < 128, 1'b1, ks);
        if (has_msg) for (int i = 0; i < 128; i++) begin
            ref_step(msg[i], 1'b1, 1'b0, ks);
            ct[i] = msg[i] ^ ks;
        end
        for (int i = 0; i < 256; i++) ref_step(i == 0, i < 128, 1'b0, ks);
        for (int i = 0; i < 768; i++) begin
            ref_step(1'b0, 1'b1, 1'b1, ks);
            if (i >= 640) tag[i-640] = ks;
        end
    endtask

    task automatic run(input int s, input bit dec, input logic [127:0] ad, input logic [127:0] msg,
                       input logic [127:0] texp, input int nad, input int nmsg, input bit stall,
                       input int abort_at, input int pulse_at,
                       output logic [127:0] res, output logic [127:0] tag, output logic ok, output int cyc);
        int w, n, p, q, win;
        logic [255:0] strm;
        logic [127:0] prev_od;
        bit hold, got, aborted;
        w = (s == 0) ? 8 : (s == 1) ? 32 : 128;
        strm = (nad != 0) ? {msg, ad} : {128'd0, msg};
        res = '0; tag = '0; ok = 1'b0; cyc = 0;
        n = 0; p = 0; q = 0; win = -1; hold = 0; got = 0; aborted = 0; prev_od = '0;
        sel = s;
        @(negedge clk);
        decrypt = dec; tag_exp = texp; ad_words = 16'(nad); msg_words = 16'(nmsg);
        in_valid = 1'b0; out_ready = 1'b1; start[s] = 1'b1;
        @(posedge clk); n = 1;
        @(negedge clk); start[s] = 1'b0;
        while (n < 3000 && !got && !aborted) begin
            if (abort_at > 0 && p == nad + abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy[s], 0);
                check("rst_in_ready", rdy[s], 0);
                check("rst_out_valid", ov[s], 0);
                check("rst_out_data", cur_od, 0);
                check("rst_done", done[s], 0);
                check("rst_tag", tg[s], 0);
                check("rst_tag_ok", tok[s], 0);
                @(posedge clk); @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
            end else begin
                start[s] = (n == pulse_at);
                in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data = (p < nad + nmsg) ? 128'(strm >> (p * w)) : 128'hDEADBEEF_5A5A5A5A_DEADBEEF_5A5A5A5A;
                if (stall && win < 0 && ov[s]) win = n;
                out_ready = !(stall && win >= 0 && n < win + 10);
                #1;
                if (done[s]) begin
                    got = 1; tag = tg[s]; ok = tok[s]; cyc = n;
                end else begin
                    if (n == 1) check("busy", busy[s], 1);
                    if (hold) check("stall_stable", cur_od, prev_od);
                    hold = ov[s] && !out_ready;
                    prev_od = cur_od;
                    if (ov[s] && out_ready) begin
                        res = res | (cur_od << (q * w));
                        q++;
                    end
                    if (in_valid && rdy[s]) p++;
                    @(posedge clk); n++;
                    @(negedge clk);
                end
            end
        end
        start[s] = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (!aborted) begin
            check("done_seen", got, 1);
            check("words_in", p, nad + nmsg);
            check("words_out", q, nmsg);
        end
    endtask

    initial begin
        logic [127:0] ad, pt, ct_ref, tag_ref, tag0_ref, ct_got, res, tg_got, dummy;
        logic ok;
        int cyc;
        rst_n = 1'b0; start = '0; decrypt = 1'b0; key = '0; iv = '0; tag_exp = '0;
        ad_words = '0; msg_words = '0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; sel = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", rdy[1], 0);
        check("reset_out_valid", ov[1], 0);
        check("reset_busy", busy[1], 0);
        check("reset_done", done[1], 0);
        check("reset_tag_ok", tok[1], 0);
        check("reset_out_data", od32, 0);
        check("reset_tag", tg[1], 0);
        rst_n = 1'b1;

        // Empty AD and message, all-zero key and IV
        ref_run('0, '0, '0, '0, 1'b0, 1'b0, dummy, tag0_ref);
        run(1, 1'b0, '0, '0, '0, 0, 0, 1'b0, 0, -1, res, tg_got, ok, cyc);
        check("empty_latency", cyc, 97);
        check("empty_tag_ok", ok, 1);
        check("empty_tag", tg_got, tag0_ref);

        key = 128'h00112233445566778899AABBCCDDEEFF;
        iv  = 128'h0123456789ABCDEF0123456789ABCDEF;
        ad  = 128'h0F0E0D0C0B0A09080706050403020100;
        pt  = 128'hAABBCCDDEEFF00112233445566778899;
        ref_run(key, iv, ad, pt, 1'b1, 1'b1, ct_ref, tag_ref);

        run(1, 1'b0, ad, pt, '0, 4, 4, 1'b0, 0, -1, ct_got, tg_got, ok, cyc);
        check("enc32_ct", ct_got, ct_ref);
        check("enc32_tag", tg_got, tag_ref);
        check("enc32_tag_ok", ok, 1);
        check("enc32_latency", cyc, 105);

        run(1, 1'b1, ad, ct_got, tg_got, 4, 4, 1'b0, 0, -1, res, dummy, ok, cyc);
        check("dec32_pt", res, pt);
        check("dec32_tag", dummy, tag_ref);
        check("dec32_tag_ok", ok, 1);

        run(1, 1'b1, ad, ct_ref, tag_ref ^ 128'd1, 4, 4, 1'b0, 0, -1, res, dummy, ok, cyc);
        check("dec32_badtag_ok", ok, 0);
        check("dec32_badtag_pt", res, pt);

        run(0, 1'b0, ad, pt, '0, 16, 16, 1'b0, 0, -1, res, tg_got, ok, cyc);
        check("enc8_ct", res, ct_ref);
        check("enc8_tag", tg_got, tag_ref);
        check("enc8_latency", cyc, 417);

        run(2, 1'b0, ad, pt, '0, 1, 1, 1'b0, 0, -1, res, tg_got, ok, cyc);
        check("enc128_ct", res, ct_ref);
        check("enc128_tag", tg_got, tag_ref);
        check("enc128_latency", cyc, 27);

        run(1, 1'b0, ad, pt, '0, 4, 4, 1'b1, 0, -1, res, tg_got, ok, cyc);
        check("stall_ct", res, ct_ref);
        check("stall_tag", tg_got, tag_ref);

        run(1, 1'b0, ad, pt, '0, 4, 4, 1'b0, 1, -1, res, tg_got, ok, cyc);
        run(1, 1'b0, ad, pt, '0, 4, 4, 1'b0, 0, -1, res, tg_got, ok, cyc);
        check("post_reset_ct", res, ct_ref);
        check("post_reset_tag", tg_got, tag_ref);

        run(1, 1'b0, ad, pt, '0, 4, 4, 1'b0, 0, 90, res, tg_got, ok, cyc);
        check("start_in_final_latency", cyc, 105);
        check("start_in_final_tag", tg_got, tag_ref);
        check("start_in_final_ct", res, ct_ref);

        repeat (3) @(posedge clk);
        #1;
        check("idle_after_runs", busy[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
